// File: rtl/pair_serializer_pkg.sv
// rtl/pair_serializer_pkg.sv - shared state encoding and beat-count helper for pair_serializer
package pair_serializer_pkg;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    function automatic int beats_per_word(input int width);
        return width / 2;
    endfunction

endpackage

// File: rtl/pair_serializer.sv
// rtl/pair_serializer.sv - serializes a parallel word into LSB-first bit pairs, one pair per clock
module pair_serializer
    import pair_serializer_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_1,
    output logic             out_2,
    output logic             out_valid,
    output logic             out_last
);

    localparam int NB = beats_per_word(WIDTH);
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;

    state_t           state;
    logic [CW-1:0]    beat;
    logic [CW-1:0]    next_beat;
    logic [WIDTH-1:0] shreg;
    logic             last_beat;
    logic             accept;

    assign last_beat = (beat == CW'(NB - 1));
    assign next_beat = beat + CW'(1);
    assign accept    = in_valid && in_ready;

    always_comb begin
        in_ready = !flush && ((state == S_IDLE) || ((state == S_SHIFT) && last_beat));
    end

    // shreg holds only the pairs not yet driven; the current pair lives in out_1/out_2
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            beat      <= '0;
            shreg     <= '0;
            out_1     <= 1'b0;
            out_2     <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (flush) begin
            state     <= S_IDLE;
            beat      <= '0;
            shreg     <= '0;
            out_1     <= 1'b0;
            out_2     <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (accept) begin
            state     <= S_SHIFT;
            beat      <= '0;
            shreg     <= in_data >> 2;
            out_1     <= in_data[1];
            out_2     <= in_data[0];
            out_valid <= 1'b1;
            out_last  <= (NB == 1);
        end else if ((state == S_SHIFT) && !last_beat) begin
            beat      <= next_beat;
            shreg     <= shreg >> 2;
            out_1     <= shreg[1];
            out_2     <= shreg[0];
            out_valid <= 1'b1;
            out_last  <= (next_beat == CW'(NB - 1));
        end else begin
            state     <= S_IDLE;
            beat      <= '0;
            shreg     <= '0;
            out_1     <= 1'b0;
            out_2     <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pair_serializer.sv
// tb/tb_pair_serializer.sv - randomized self-checking bench for pair_serializer against a word/beat-index model
module tb_pair_serializer;

    localparam int WIDTH = 8;
    localparam int NB    = WIDTH / 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_1;
    logic             out_2;
    logic             out_valid;
    logic             out_last;

    int checks   = 0;
    int failures = 0;

    // reference: the word being sent, whether a word is on the wire, and which pair is showing
    bit             m_active = 1'b0;
    logic [WIDTH-1:0] m_word = '0;
    int             m_k      = 0;

    logic [WIDTH-1:0] src_q[$];

    pair_serializer #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_1    (out_1),
        .out_2    (out_2),
        .out_valid(out_valid),
        .out_last (out_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        int pair;
        pair = m_active ? int'((m_word >> (2 * m_k)) & 3) : 0;
        chk("pair",      int'({out_1, out_2}), pair);
        chk("out_valid", int'(out_valid), int'(m_active));
        chk("out_last",  int'(out_last),  int'(m_active && (m_k == NB - 1)));
    endtask

    // one clock: drive at posedge+1, check ready, advance model at the edge, check outputs at posedge+1
    task automatic tick(input bit v, input logic [WIDTH-1:0] d, input bit f, output bit acc);
        bit exp_ready;
        in_valid = v;
        in_data  = d;
        flush    = f;
        #1;
        exp_ready = !f && (!m_active || (m_k == NB - 1));
        chk("in_ready", int'(in_ready), int'(exp_ready));
        acc = v && exp_ready;
        @(posedge clk);
        if (f) begin
            m_active = 1'b0;
            m_k      = 0;
        end else if (acc) begin
            m_active = 1'b1;
            m_word   = d;
            m_k      = 0;
        end else if (m_active && (m_k < NB - 1)) begin
            m_k++;
        end else begin
            m_active = 1'b0;
            m_k      = 0;
        end
        #1;
        check_outputs();
    endtask

    task automatic send_cycle(input bit f);
        bit               v;
        bit               acc;
        logic [WIDTH-1:0] d;
        v = (src_q.size() > 0);
        d = v ? src_q[0] : WIDTH'($urandom);
        tick(v, d, f, acc);
        if (acc) void'(src_q.pop_front());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b1;
        in_data  = WIDTH'($urandom);

        // reset hold with in_valid high: nothing accepted
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_outputs();
        end
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("ready_after_reset", int'(in_ready), 1);
        @(posedge clk);
        #1;

        // single word B4 -> 00,01,11,10 then idle
        src_q.push_back(8'hB4);
        for (int i = 0; i < 6; i++) send_cycle(1'b0);

        // back-to-back FF then 01, no bubble
        src_q.push_back(8'hFF);
        src_q.push_back(8'h01);
        for (int i = 0; i < 10; i++) send_cycle(1'b0);

        // flush at beat 1 of AA, then 0C serializes cleanly
        src_q.push_back(8'hAA);
        send_cycle(1'b0);
        send_cycle(1'b0);
        send_cycle(1'b1);
        src_q.push_back(8'h0C);
        for (int i = 0; i < 6; i++) send_cycle(1'b0);

        // asynchronous reset at beat 2, between edges
        src_q.push_back(8'h9C);
        for (int i = 0; i < 3; i++) send_cycle(1'b0);
        #2;
        rst = 1'b0;
        m_active = 1'b0;
        m_k = 0;
        #1;
        check_outputs();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) send_cycle(1'b0);

        // randomized traffic with occasional flush
        for (int i = 0; i < 400; i++) begin
            if ((src_q.size() == 0) && ($urandom_range(0, 2) != 0))
                src_q.push_back(WIDTH'($urandom));
            send_cycle($urandom_range(0, 15) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
